irq_sequencer: RTL and testbench

Interrupt entry/exit sequencer for the pipelined RAT CPU. It sits between the external interrupt pin and the pipeline. It latches interrupt requests, waits for a safe point, drains the decode stage, injects the INT micro-op into the decoder, and steers fetch and the PC to the interrupt vector. It then tracks the in-service period until RETIE retires in execute.

---
 rtl/rat_pipe_pkg.sv | 16 +
 rtl/irq_edge_latch.sv | 68 ++++++
 rtl/irq_sequencer.sv | 94 +++++++++
 tb/tb_irq_sequencer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/rat_pipe_pkg.sv
// Shared definitions for the RAT CPU pipeline control blocks: interrupt
// sequencer state encoding and the PC/vector constants.
package rat_pipe_pkg;

  localparam int RAT_PC_W = 10;
  localparam logic [RAT_PC_W-1:0] RAT_VEC_ADDR = 10'h3FF;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRAIN  = 3'd1,
    INJECT = 3'd2,
    VECTOR = 3'd3,
    ISR    = 3'd4
  } irq_state_t;

endpackage

// File: rtl/irq_edge_latch.sv
// Interrupt request front end: optional 2-flop synchronizer, rising-edge
// detect, pending and sticky overrun flags. Macro IRQ_SYNC_EN enables the synchronizer.
module irq_edge_latch
  import rat_pipe_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic irq_in,
  input  logic clr_pending,
  output logic irq_pending,
  output logic irq_overrun
);

  logic irq_s;
  logic irq_dly_q, irq_dly_d;
  logic pending_q, pending_d;
  logic overrun_q, overrun_d;
  logic edge_det;

`ifdef IRQ_SYNC_EN
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;

  always_comb begin
    sync1_d = irq_in;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign irq_s = sync2_q;
`else
  assign irq_s = irq_in;
`endif

  assign edge_det = irq_s & ~irq_dly_q;

  // A fresh edge beats the clear so a request landing in INJECT is not lost.
  always_comb begin
    irq_dly_d = irq_s;
    pending_d = edge_det | (pending_q & ~clr_pending);
    overrun_d = overrun_q | (edge_det & pending_q);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      irq_dly_q <= 1'b0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      irq_dly_q <= irq_dly_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  assign irq_pending = pending_q;
  assign irq_overrun = overrun_q;

endmodule

// File: rtl/irq_sequencer.sv
// Interrupt entry/exit sequencer: drains decode, injects INT, vectors the PC
// and tracks the ISR until RETIE. Optional macro IRQ_SYNC_EN adds an input synchronizer.
module irq_sequencer
  import rat_pipe_pkg::*;
#(
  parameter int              PC_W     = RAT_PC_W,
  parameter logic [PC_W-1:0] VEC_ADDR = RAT_VEC_ADDR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            irq_in,
  input  logic            i_en,
  input  logic            ex_branch,
  input  logic            mem_stall,
  input  logic            reti_ex,
  output logic            dec_nop,
  output logic            fetch_stall,
  output logic            dec_int,
  output logic            vec_sel,
  output logic            pc_vec_ld,
  output logic [PC_W-1:0] vec_addr,
  output logic            in_service,
  output logic            irq_pending,
  output logic            irq_overrun
);

  irq_state_t state_q, state_d;
  logic       clr_pending;

  irq_edge_latch u_edge_latch (
    .clk         (clk),
    .rst         (rst),
    .irq_in      (irq_in),
    .clr_pending (clr_pending),
    .irq_pending (irq_pending),
    .irq_overrun (irq_overrun)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Strobes decode from state_q only; once DRAIN is entered the entry is committed.
  always_comb begin
    state_d     = state_q;
    dec_nop     = 1'b0;
    fetch_stall = 1'b0;
    dec_int     = 1'b0;
    vec_sel     = 1'b0;
    pc_vec_ld   = 1'b0;
    in_service  = 1'b0;
    clr_pending = 1'b0;
    case (state_q)
      IDLE: begin
        if (irq_pending && i_en && !ex_branch && !mem_stall) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        dec_nop     = 1'b1;
        fetch_stall = 1'b1;
        state_d     = INJECT;
      end
      INJECT: begin
        dec_int     = 1'b1;
        fetch_stall = 1'b1;
        clr_pending = 1'b1;
        state_d     = VECTOR;
      end
      VECTOR: begin
        vec_sel     = 1'b1;
        pc_vec_ld   = 1'b1;
        fetch_stall = 1'b1;
        state_d     = ISR;
      end
      ISR: begin
        in_service = 1'b1;
        if (reti_ex) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign vec_addr = VEC_ADDR;

endmodule

// File: tb/tb_irq_sequencer.sv
// Bench for irq_sequencer: vector table, directed corner sequences and a
// randomized run against a phase-counter reference model.
module tb_irq_sequencer;

`ifdef IRQ_SYNC_EN
  localparam int SD = 2;
`else
  localparam int SD = 0;
`endif

  logic       clk = 1'b0;
  logic       rst, irq_in, i_en, ex_branch, mem_stall, reti_ex;
  logic       dec_nop, fetch_stall, dec_int, vec_sel, pc_vec_ld;
  logic       in_service, irq_pending, irq_overrun;
  logic [9:0] vec_addr;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  irq_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .irq_in      (irq_in),
    .i_en        (i_en),
    .ex_branch   (ex_branch),
    .mem_stall   (mem_stall),
    .reti_ex     (reti_ex),
    .dec_nop     (dec_nop),
    .fetch_stall (fetch_stall),
    .dec_int     (dec_int),
    .vec_sel     (vec_sel),
    .pc_vec_ld   (pc_vec_ld),
    .vec_addr    (vec_addr),
    .in_service  (in_service),
    .irq_pending (irq_pending),
    .irq_overrun (irq_overrun)
  );

  // Reference model: entry phase 0 = idle, 1..3 = the three entry cycles, 4 = in service.
  bit m_h1, m_h2, m_prev, m_pend, m_ovr;
  int m_phase;

  task automatic model_edge();
    bit s, e, take, new_pend;
    if (!rst) begin
      m_h1 = 0; m_h2 = 0; m_prev = 0; m_pend = 0; m_ovr = 0; m_phase = 0;
    end else begin
      s = (SD == 2) ? m_h2 : irq_in;
      e = s & ~m_prev;
      take = m_pend & i_en & ~ex_branch & ~mem_stall;
      new_pend = e | (m_pend & (m_phase != 2));
      m_ovr = m_ovr | (e & m_pend);
      if (m_phase == 0) m_phase = take ? 1 : 0;
      else if (m_phase < 4) m_phase = m_phase + 1;
      else if (reti_ex) m_phase = 0;
      m_pend = new_pend;
      m_h2 = m_h1;
      m_h1 = irq_in;
      m_prev = s;
    end
  endtask

  function automatic logic [7:0] model_vec();
    return {m_phase == 1, (m_phase >= 1 && m_phase <= 3), m_phase == 2,
            m_phase == 3, m_phase == 3, m_phase == 4, m_pend, m_ovr};
  endfunction

  function automatic logic [7:0] dut_vec();
    return {dec_nop, fetch_stall, dec_int, vec_sel, pc_vec_ld, in_service,
            irq_pending, irq_overrun};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 'h%0h, expected 'h%0h", name, got, exp);
  endtask

  task automatic step(input logic r, input logic irq, input logic ie, input logic br,
                      input logic ms, input logic rt);
    rst = r; irq_in = irq; i_en = ie; ex_branch = br; mem_stall = ms; reti_ex = rt;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Raise a request with interrupts masked, bounded wait for the pending flag.
  task automatic raise_pending();
    for (int k = 0; k < 8; k++) begin
      step(1, 1, 0, 0, 0, 0);
      if (irq_pending === 1'b1) break;
    end
    check("raise_pending", irq_pending, 1);
  endtask

  typedef struct packed {
    logic       irq;
    logic       ien;
    logic       br;
    logic       ms;
    logic       reti;
    logic [7:0] exp;  // {nop, fstall, int, vsel, pcld, isr, pend, ovr}
  } vec_t;

  vec_t tbl[12];
  int   n_int;

  initial begin
    tbl[0]  = '{irq:0, ien:1, br:1, ms:0, reti:0, exp:8'b0000_0010};
    tbl[1]  = '{irq:0, ien:1, br:1, ms:0, reti:0, exp:8'b0000_0010};
    tbl[2]  = '{irq:0, ien:1, br:1, ms:0, reti:0, exp:8'b0000_0010};
    tbl[3]  = '{irq:0, ien:1, br:0, ms:1, reti:0, exp:8'b0000_0010};
    tbl[4]  = '{irq:0, ien:1, br:0, ms:1, reti:0, exp:8'b0000_0010};
    tbl[5]  = '{irq:0, ien:1, br:0, ms:0, reti:0, exp:8'b1100_0010};
    tbl[6]  = '{irq:0, ien:0, br:1, ms:0, reti:0, exp:8'b0110_0010};
    tbl[7]  = '{irq:0, ien:0, br:0, ms:1, reti:0, exp:8'b0101_1000};
    tbl[8]  = '{irq:0, ien:0, br:0, ms:0, reti:0, exp:8'b0000_0100};
    tbl[9]  = '{irq:0, ien:1, br:0, ms:0, reti:0, exp:8'b0000_0100};
    tbl[10] = '{irq:0, ien:1, br:0, ms:0, reti:1, exp:8'b0000_0000};
    tbl[11] = '{irq:0, ien:1, br:0, ms:0, reti:1, exp:8'b0000_0000};

    // Reset held with the request line high
    for (int k = 0; k < 4; k++) begin
      step(0, 1, 1, 0, 0, 0);
      check("reset_outs", dut_vec(), 8'h00);
    end
    check("reset_vec_addr", vec_addr, 10'h3FF);
    step(1, 0, 0, 0, 0, 0);
    check("post_reset", dut_vec(), 8'h00);
    check("post_reset_model", dut_vec(), model_vec());

    // Blocked entry, then the basic entry/exit sequence
    raise_pending();
    for (int i = 0; i < 12; i++) begin
      step(1, tbl[i].irq, tbl[i].ien, tbl[i].br, tbl[i].ms, tbl[i].reti);
      check($sformatf("tbl%0d", i), dut_vec(), tbl[i].exp);
      check($sformatf("tbl%0d_model", i), dut_vec(), model_vec());
    end

    // Masked request stays pending until i_en rises
    raise_pending();
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 0, 0, 0, 0);
      check("masked_hold", dut_vec(), 8'b0000_0010);
    end
    step(1, 0, 1, 0, 0, 0);
    check("unmask_drain", dut_vec(), 8'b1100_0010);
    for (int k = 0; k < 3; k++) step(1, 0, 1, 0, 0, 0);
    check("masked_isr", dut_vec(), 8'b0000_0100);
    step(1, 0, 1, 0, 0, 1);
    check("masked_exit", dut_vec(), 8'b0000_0000);

    // Two edges coalesce: overrun set, exactly one entry
    step(1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < SD; k++) step(1, 0, 0, 0, 0, 0);
    check("overrun_set", dut_vec(), 8'b0000_0011);
    n_int = 0;
    for (int k = 0; k < 8; k++) begin
      step(1, 0, 1, 0, 0, 0);
      if (dec_int === 1'b1) n_int++;
    end
    check("coalesce_entries", n_int, 1);
    check("coalesce_isr", dut_vec(), 8'b0000_0101);
    // Edge during ISR is held, then taken two cycles after reti_ex
    step(1, 1, 1, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0);
    for (int k = 0; k < SD; k++) step(1, 0, 1, 0, 0, 0);
    check("isr_latch", dut_vec(), 8'b0000_0111);
    step(1, 0, 1, 0, 0, 1);
    check("isr_exit_idle", dut_vec(), 8'b0000_0011);
    step(1, 0, 1, 0, 0, 0);
    check("second_entry", dut_vec(), 8'b1100_0011);
    for (int k = 0; k < 3; k++) step(1, 0, 1, 0, 0, 0);
    step(1, 0, 1, 0, 0, 1);
    check("second_exit", dut_vec(), model_vec());

    // Reset landing in INJECT
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    raise_pending();
    step(1, 0, 1, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0);
    check("inject_reached", dec_int, 1);
    step(0, 0, 1, 0, 0, 0);
    check("midseq_reset", dut_vec(), 8'h00);
    step(1, 0, 1, 0, 0, 0);
    check("midseq_after", dut_vec(), 8'h00);

    // Randomized run against the model
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(63) != 0), ($urandom_range(3) == 0) ? ~irq_in : irq_in,
           ($urandom_range(3) != 0), ($urandom_range(2) == 0),
           ($urandom_range(3) == 0), ($urandom_range(7) == 0));
      check($sformatf("rand%0d", k), dut_vec(), model_vec());
    end
    check("rand_vec_addr", vec_addr, 10'h3FF);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
